// File: rtl/fifo_pkg.sv
// Shared FIFO parameters: the async FIFO and its read-side packer both size
// themselves from these defaults.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 4;
    localparam int PACK_RATIO_DEF = 4;

    // Counter must reach PACK_RATIO itself, hence the +1.
    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_width(PACK_RATIO_DEF);

endpackage

// File: rtl/fifo_rd_packer.sv
// Reads PACK_RATIO words from an async FIFO read port and presents them as one
// wide word with a valid/ready handshake. First word read lands in the LSBs.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int PACK_RATIO = PACK_RATIO_DEF
) (
    input  logic                             i_rclk,
    input  logic                             i_rst,
    input  logic                             i_rempty,
    input  logic [FIFO_WIDTH-1:0]            i_rdata,
    output logic                             o_ren,
    input  logic                             i_flush,
    output logic                             o_valid,
    output logic [FIFO_WIDTH*PACK_RATIO-1:0] o_data,
    input  logic                             i_ready
);

    localparam int CNT_W = cnt_width(PACK_RATIO);
    localparam int OUT_W = FIFO_WIDTH * PACK_RATIO;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_RATIO);
    localparam logic [CNT_W:0]   FULL_OCC = (CNT_W + 1)'(PACK_RATIO);

    logic [CNT_W-1:0]                       r_cnt;
    logic                                   r_inflight;
    logic [PACK_RATIO-1:0][FIFO_WIDTH-1:0]  r_pack;
    logic [OUT_W-1:0]                       r_data;
    logic                                   r_valid;

    logic [CNT_W:0]                         w_occ;
    logic                                   w_ren;
    logic                                   w_capture;
    logic                                   w_xfer;
    logic [CNT_W-1:0]                       w_cnt_nxt;

    // Read gating, capture/transfer decisions and next counter value.
    always_comb begin
        w_occ     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight};
        w_ren     = 1'b0;
        w_capture = r_inflight && !i_flush;
        w_xfer    = (r_cnt == FULL_CNT) && (!r_valid || i_ready) && !i_flush;
        w_cnt_nxt = r_cnt;

        // Counting the in-flight word keeps a capture from ever finding a full register.
        if (!i_rst && !i_rempty && !i_flush && (w_occ < FULL_OCC)) begin
            w_ren = 1'b1;
        end else begin
            w_ren = 1'b0;
        end

        if (i_flush) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_xfer) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_capture) begin
            w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Slot counter and in-flight flag; a read accepted now returns data next cycle.
    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= {CNT_W{1'b0}};
            r_inflight <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_inflight <= w_ren;
        end
    end

    // Pack register, written one slot at a time at the current count.
    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            r_pack <= '0;
        end else begin
            for (int s = 0; s < PACK_RATIO; s++) begin
                if (w_capture && (r_cnt == CNT_W'(s))) begin
                    r_pack[s] <= i_rdata;
                end else begin
                    r_pack[s] <= r_pack[s];
                end
            end
        end
    end

    // Output register: loads on transfer, otherwise holds until accepted.
    always_ff @(posedge i_rclk or posedge i_rst) begin
        if (i_rst) begin
            r_data  <= {OUT_W{1'b0}};
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_data  <= r_pack;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_data  <= r_data;
            r_valid <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end
    end

    assign o_ren   = w_ren;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO, packed-word scoreboard,
// table-driven groups and directed stall/flush/reset sequences.
module tb_fifo_rd_packer;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int OW = W * R;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rempty = 1'b1;
    logic          flush = 1'b0;
    logic          ready = 1'b1;
    logic          ren;
    logic          valid;
    logic [W-1:0]  rdata = '0;
    logic [OW-1:0] data;

    always #5 clk = ~clk;

    fifo_rd_packer #(.FIFO_WIDTH(W), .PACK_RATIO(R)) dut (
        .i_rclk  (clk),
        .i_rst   (rst),
        .i_rempty(rempty),
        .i_rdata (rdata),
        .o_ren   (ren),
        .i_flush (flush),
        .o_valid (valid),
        .o_data  (data),
        .i_ready (ready)
    );

    typedef struct {
        logic [W-1:0]  w0, w1, w2, w3;
        logic [OW-1:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [W-1:0]  mem [0:4095];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    bit            force_empty = 1'b0;
    int            reads = 0;
    int            cyc = 0;
    bit            inflight_m = 1'b0;
    int            part_n = 0;
    logic [OW-1:0] part_v = '0;
    int            grp_edge = -100;
    bit            lat_en = 1'b0;
    bit            prev_valid = 1'b0;
    bit            prev_ready = 1'b0;
    logic [OW-1:0] prev_data = '0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] out_log [$];

    function automatic void check(input bit ok, input string name,
                                  input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void update_empty();
        rempty = force_empty || (rd_ptr == wr_ptr);
    endfunction

    task automatic push(input logic [W-1:0] v);
        mem[wr_ptr] = v;
        wr_ptr++;
        update_empty();
    endtask

    // One clock: monitor just before the edge, then update FIFO/model at the edge.
    task automatic step();
        bit acc;
        bit cap;
        @(negedge clk);
        acc = ren && !rempty;
        cap = inflight_m && !flush;
        if (ren) begin
            check(!rempty && !flush, "ren_gate", {15'd0, ren}, 16'd0);
            check((part_n + int'(inflight_m) < R) && (exp_q.size() <= 1), "ren_bound",
                  16'(part_n + int'(inflight_m)), 16'(R - 1));
        end
        if (prev_valid && !prev_ready) begin
            check(valid && (data == prev_data), "hold_stable", data, prev_data);
        end
        if (lat_en && valid && !prev_valid) begin
            check((cyc - 1 - grp_edge) == 2 - 1, "latency", 16'(cyc - 1 - grp_edge), 16'd1);
        end
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_out", data, 16'd0);
            end else begin
                logic [OW-1:0] e;
                e = exp_q.pop_front();
                check(data == e, "out_data", data, e);
            end
            out_log.push_back(data);
        end
        prev_valid = valid;
        prev_ready = ready;
        prev_data  = data;
        @(posedge clk);
        if (rst) begin
            part_n = 0;
            part_v = '0;
            exp_q.delete();
        end else if (flush) begin
            part_n = 0;
            part_v = '0;
        end else if (cap) begin
            part_v[part_n*W +: W] = rdata;
            part_n++;
            if (part_n == R) begin
                exp_q.push_back(part_v);
                part_n   = 0;
                part_v   = '0;
                grp_edge = cyc;
            end
        end
        inflight_m = acc;
        if (acc) reads++;
        #1;
        if (acc) begin
            rdata = mem[rd_ptr];
            rd_ptr++;
        end else begin
            rdata = W'($urandom);
        end
        cyc++;
        update_empty();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check(valid == 1'b0, "rst_valid", {15'd0, valid}, 16'd0);
        check(data == '0, "rst_data", data, 16'd0);
        check(ren == 1'b0, "rst_ren", {15'd0, ren}, 16'd0);
        exp_q.delete();
        part_n = 0;
        part_v = '0;
        inflight_m = 1'b0;
        prev_valid = 1'b0;
        step();
        rst = 1'b0;
        prev_valid = 1'b0;
    endtask

    vec_t tbl [4];

    initial begin
        bit got;
        bit hit;

        tbl[0] = '{w0: 4'h1, w1: 4'h2, w2: 4'h3, w3: 4'h4, exp: 16'h4321};
        tbl[1] = '{w0: 4'hF, w1: 4'h0, w2: 4'hF, w3: 4'h0, exp: 16'h0F0F};
        tbl[2] = '{w0: 4'h0, w1: 4'h0, w2: 4'h0, w3: 4'h8, exp: 16'h8000};
        tbl[3] = '{w0: 4'hE, w1: 4'h5, w2: 4'hA, w3: 4'h3, exp: 16'h3A5E};

        #2;
        do_reset();

        // Eight primed words, downstream always ready.
        lat_en = 1'b1;
        out_log.delete();
        for (int i = 1; i <= 8; i++) push(W'(i));
        run(20);
        check(out_log.size() == 2, "prime_count", 16'(out_log.size()), 16'd2);
        if (out_log.size() == 2) begin
            check(out_log[0] == 16'h4321, "prime_w0", out_log[0], 16'h4321);
            check(out_log[1] == 16'h8765, "prime_w1", out_log[1], 16'h8765);
        end

        for (int i = 0; i < 4; i++) begin
            push(tbl[i].w0);
            push(tbl[i].w1);
            push(tbl[i].w2);
            push(tbl[i].w3);
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                if (valid) begin
                    got = 1'b1;
                    check(data == tbl[i].exp, "tbl_data", data, tbl[i].exp);
                end
            end
            if (!got) check(1'b0, "tbl_timeout", 16'(i), tbl[i].exp);
            run(3);
        end
        lat_en = 1'b0;

        // Stalled output: exactly two groups read, then drain in order.
        ready = 1'b0;
        out_log.delete();
        reads = 0;
        for (int i = 1; i <= 12; i++) push(W'(i));
        run(30);
        check(reads == 8, "stall_reads", 16'(reads), 16'd8);
        check(ren == 1'b0, "stall_ren", {15'd0, ren}, 16'd0);
        check(valid && data == 16'h4321, "stall_word", data, 16'h4321);
        ready = 1'b1;
        run(30);
        check(out_log.size() == 3, "stall_count", 16'(out_log.size()), 16'd3);
        if (out_log.size() == 3) begin
            check(out_log[0] == 16'h4321, "stall_o0", out_log[0], 16'h4321);
            check(out_log[1] == 16'h8765, "stall_o1", out_log[1], 16'h8765);
            check(out_log[2] == 16'hCBA9, "stall_o2", out_log[2], 16'hCBA9);
        end

        // Empty flag toggling every 3 cycles while words trickle in.
        out_log.delete();
        for (int k = 0; k < 60; k++) begin
            force_empty = ((k / 3) % 2) == 1;
            if (k == 0)  push(4'hA);
            if (k == 7)  push(4'hB);
            if (k == 14) push(4'hC);
            if (k == 21) push(4'hD);
            update_empty();
            step();
        end
        force_empty = 1'b0;
        update_empty();
        run(10);
        check(out_log.size() == 1, "trickle_count", 16'(out_log.size()), 16'd1);
        if (out_log.size() == 1) check(out_log[0] == 16'hDCBA, "trickle_word", out_log[0], 16'hDCBA);

        // Flush with two words held and one in flight.
        out_log.delete();
        push(4'h1);
        push(4'h2);
        push(4'h3);
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            hit = (part_n == 2) && inflight_m;
        end
        check(hit, "flush_setup", {15'd0, hit}, 16'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        run(5);
        check(out_log.size() == 0, "flush_nothing", 16'(out_log.size()), 16'd0);
        for (int i = 5; i <= 8; i++) push(W'(i));
        run(15);
        check(out_log.size() == 1, "flush_count", 16'(out_log.size()), 16'd1);
        if (out_log.size() == 1) check(out_log[0] == 16'h8765, "flush_word", out_log[0], 16'h8765);

        // Reset while a word is held and three slots are filled.
        ready = 1'b0;
        for (int i = 1; i <= 7; i++) push(W'(i));
        hit = 1'b0;
        for (int k = 0; k < 30 && !hit; k++) begin
            step();
            hit = (exp_q.size() == 1) && (part_n == 3) && !inflight_m;
        end
        check(hit, "rst_setup", {15'd0, hit}, 16'd1);
        check(valid == 1'b1, "rst_pre_valid", {15'd0, valid}, 16'd1);
        do_reset();
        ready = 1'b1;
        out_log.delete();
        push(4'h9);
        push(4'hA);
        push(4'hB);
        push(4'hC);
        run(15);
        check(out_log.size() == 1, "rst_count", 16'(out_log.size()), 16'd1);
        if (out_log.size() == 1) check(out_log[0] == 16'hCBA9, "rst_word", out_log[0], 16'hCBA9);

        // Random empty/ready traffic against the scoreboard.
        out_log.delete();
        for (int k = 0; k < 2000; k++) begin
            force_empty = ($urandom_range(0, 2) == 0);
            ready = ($urandom_range(0, 3) != 0);
            if ((wr_ptr - rd_ptr) < 6) push(W'($urandom));
            update_empty();
            step();
        end
        force_empty = 1'b0;
        ready = 1'b1;
        update_empty();
        run(40);
        check(exp_q.size() == 0, "rand_drain", 16'(exp_q.size()), 16'd0);
        check(out_log.size() > 100, "rand_progress", 16'(out_log.size()), 16'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
